// File: rtl/nmx1_pkg.sv
// rtl/nmx1_pkg.sv - shared types and widths for the Neuromorphic_X1 Wishbone host sequencer
//
// Purpose : bus widths, sequencer state encoding and the buffered command
//           record shared by the FIFO and the sequencer top.
// Contents: WB_ADR_W, WB_DAT_W, state_t {IDLE, REQ, RSP},
//           cmd_t {we, sel[3:0], adr[31:0], dat[31:0]} (69 bits), CMD_W.
package nmx1_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                we;
    logic [3:0]          sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/nmx1_sync_fifo.sv
// rtl/nmx1_sync_fifo.sv - single-clock command FIFO with occupancy count
//
// Purpose : buffers command records between the command source and the
//           Wishbone sequencer. rd_data always shows the head entry.
// Ports   : clk, rst_n (async, active low)
//           wr_en/wr_data  - push (ignored when full unless popping too)
//           rd_en/rd_data  - pop / head entry (ignored when empty)
//           full, empty, level[$clog2(DEPTH):0]
module nmx1_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign level   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nmx1_wb_host_seq.sv
// rtl/nmx1_wb_host_seq.sv - Wishbone classic initiator driving the Neuromorphic_X1 responder
//
// Purpose : queues local commands and issues them one single-beat Wishbone
//           cycle at a time; each command yields exactly one response
//           (read data, or rsp_err=1 when the responder never acks).
// Ports   : wb_clk_i, wb_rst_n_i (async, active low)
//           cmd_valid/cmd_ready/cmd_we/cmd_sel/cmd_adr/cmd_dat - command in
//           rsp_valid/rsp_ready/rsp_dat/rsp_err              - response out
//           wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o, wbm_dat_i/ack_i - Wishbone
//           busy, fifo_level                                  - status
module nmx1_wb_host_seq
  import nmx1_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [3:0]                    cmd_sel,
  input  logic [WB_ADR_W-1:0]           cmd_adr,
  input  logic [WB_DAT_W-1:0]           cmd_dat,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WB_DAT_W-1:0]           rsp_dat,
  output logic                          rsp_err,
  output logic                          wbm_cyc_o,
  output logic                          wbm_stb_o,
  output logic                          wbm_we_o,
  output logic [3:0]                    wbm_sel_o,
  output logic [WB_ADR_W-1:0]           wbm_adr_o,
  output logic [WB_DAT_W-1:0]           wbm_dat_o,
  input  logic [WB_DAT_W-1:0]           wbm_dat_i,
  input  logic                          wbm_ack_i,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // Last counter value before the cycle is abandoned: TIMEOUT_CYC stb cycles total.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t               r_state;
  logic [15:0]          r_cnt;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic [WB_ADR_W-1:0]  r_adr;
  logic [WB_DAT_W-1:0]  r_dat;
  logic                 r_rsp_valid;
  logic [WB_DAT_W-1:0]  r_rsp_dat;
  logic                 r_rsp_err;

  cmd_t w_cmd_in;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_cmd_in.we  = cmd_we;
  assign w_cmd_in.sel = cmd_sel;
  assign w_cmd_in.adr = cmd_adr;
  assign w_cmd_in.dat = cmd_dat;

  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign cmd_ready = !w_full || w_pop;
  assign w_push    = cmd_valid && cmd_ready;

  nmx1_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .wr_en   (w_push),
    .wr_data (w_cmd_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_we    <= w_head.we;
            r_sel   <= w_head.sel;
            r_adr   <= w_head.adr;
            r_dat   <= w_head.dat;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          // ack is checked first so an ack on the timeout cycle still completes.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else if (r_cnt == TO_LAST) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE) || !w_empty;

endmodule
